spi_wb_cmd_decoder: RTL and testbench
=====================================

// Module: spi_wb_cmd_decoder
// PURPOSE
//  Wishbone-clock-domain stage directly downstream of the SPI receive path and its clock-domain import.
//  Consumes received SPI bytes, parses a command frame and runs one classic Wishbone master cycle per frame.
//  Emits one status/read-data response per frame toward the SPI transmit path.
// PARAMETERS
//  DATA_W   32  Wishbone data width; multiple of 8, 8..64
//  ADDR_W   16  Wishbone byte-address width; >= 7 + log2(DATA_W/8)
//  TIMEOUT  255 Cycles to wait for ack/err before abort; 0 = never time out
// PORTS
//  clk         in   1         Wishbone clock; only clock of the block
//  rst_n       in   1         asynchronous, active-low reset
//  rx_stb      in   1         one-cycle pulse: rx_data holds a received byte
//  rx_data     in   8         received byte
//  rx_idle     in   1         chip-select deasserted (already synchronised); frame boundary
//  wb_cyc_o    out  1         Wishbone cycle
//  wb_stb_o    out  1         Wishbone strobe
//  wb_we_o     out  1         1 = write
//  wb_adr_o    out  ADDR_W    byte address
//  wb_dat_o    out  DATA_W    write data
//  wb_sel_o    out  DATA_W/8  byte selects; always all ones
//  wb_dat_i    in   DATA_W    read data
//  wb_ack_i    in   1         cycle acknowledge
//  wb_err_i    in   1         cycle error
//  tx_stb      out  1         one-cycle pulse: response valid
//  tx_data     out  DATA_W    read data; 0 for writes and failed cycles
//  tx_status   out  2         0 OK, 1 ERR, 2 TIMEOUT
//  overrun     out  1         sticky: a byte was dropped while busy
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0, including wb_sel_o.
//    Command, data shift register and counters are cleared.
//  - Frame format: cmd byte {we[7], waddr[6:0]}.
//    A write is followed by DATA_W/8 data bytes, MSB first. A read has no further bytes.
//  - wb_adr_o = zero-extend(waddr) << log2(DATA_W/8).
//  - IDLE: on rx_stb, latch cmd. If we=1, go to DATA with byte count 0; if we=0, go to BUS.
//  - DATA: each rx_stb shifts the byte in: dat <= {dat[DATA_W-9:0], rx_data}.
//    The last byte moves the FSM to BUS on the following clock.
//  - BUS: wb_cyc_o=wb_stb_o=1 from the first cycle in BUS until the ack/err/timeout cycle inclusive.
//    On ack: status OK and capture wb_dat_i (reads only). On err: status ERR.
//    When wb_ack_i and wb_err_i are both high, err wins.
//    Timeout: no ack/err within TIMEOUT cycles; drop cyc/stb, status TIMEOUT.
//    After any of these, go to RESP.
//  - RESP: tx_stb=1 for exactly one cycle, then IDLE.
//    Read latency: from the ack cycle to tx_stb is 1 cycle.
//  - Bus outputs are deasserted the cycle after termination. wb_dat_o/adr stay stable throughout BUS.
//  - rx_stb in BUS or RESP: byte is dropped and overrun is set. No effect on the cycle.
//  - rx_idle=1 in DATA: abort to IDLE; no bus cycle, no response.
//  - rx_idle=1 in BUS/RESP: the cycle and response still complete.
//  - rx_idle=1 clears overrun. rx_idle and rx_stb in the same cycle: byte ignored, no overrun.
//  - rx_stb in IDLE while rx_idle=1: ignored.
//  - rx_idle=1 in IDLE: FSM stays in IDLE.
//  - Timeout counter: width $clog2(TIMEOUT+1), saturating, cleared on entering BUS.
//  - Reset mid-cycle: cyc/stb drop immediately (asynchronous); no response is issued.
// STRUCTURE
//  - Package spi_wb_pkg: state enum (IDLE, DATA, BUS, RESP) and status enum (OK, ERR, TIMEOUT).
//  - Package spi_wb_pkg also holds CMD_WE_BIT=7 and CMD_ADDR_MSB=6.
//  - No sub-module: FSM, shift register and timeout counter are inline.
//  - The clock-domain import is instantiated by the parent, not here.
// TESTING
//  1. Write: bytes 0x85,DE,AD,BE,EF, ack after 2 cycles.
//     Expect wb_we_o=1, adr=0x0014, dat_o=0xDEADBEEF, sel=0xF; tx_stb with status 0, tx_data 0.
//  2. Read: byte 0x03, ack with wb_dat_i=0x12345678.
//     Expect adr=0x000C, we=0; tx_stb 1 cycle after ack with tx_data 0x12345678, status 0.
//  3. Read of 0x01 with wb_ack_i and wb_err_i both high.
//     Expect status 1, tx_data 0, cyc low next cycle.
//  4. TIMEOUT=4, read 0x02, never ack.
//     Expect cyc high exactly 4 cycles, then status 2.
//  5. Write 0x80,0x11 then rx_idle pulse: no cyc ever. Next frame 0x00 + ack: normal read.
//  6. rx_stb during BUS: overrun=1, byte lost, cycle unaffected. rx_idle pulse: overrun=0.

Source files
------------

// File: rtl/spi_wb_pkg.sv
// rtl/spi_wb_pkg.sv - shared types and command-byte field positions for the SPI command decoder
package spi_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_BUS  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_ERR     = 2'd1,
    STAT_TIMEOUT = 2'd2
  } status_e;

  localparam int CMD_WE_BIT   = 7;
  localparam int CMD_ADDR_MSB = 6;

endpackage

// File: rtl/spi_wb_cmd_decoder.sv
// rtl/spi_wb_cmd_decoder.sv - parses SPI command frames and runs one Wishbone master cycle per frame
module spi_wb_cmd_decoder
  import spi_wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_stb,
  input  logic [7:0]          rx_data,
  input  logic                rx_idle,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  output logic                tx_stb,
  output logic [DATA_W-1:0]   tx_data,
  output logic [1:0]          tx_status,
  output logic                overrun
);

  localparam int NBYTES = DATA_W / 8;
  localparam int AL     = $clog2(NBYTES);
  localparam int BW     = $clog2(NBYTES + 1);
  localparam int TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e              state_q, state_d;
  status_e             status_q, status_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic                ovr_q, ovr_d;
  logic [DATA_W/8-1:0] sel_q;

  logic byte_ok;
  assign byte_ok = rx_stb && !rx_idle;

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    cmd_d    = cmd_q;
    dat_d    = dat_q;
    rdata_d  = rdata_q;
    bcnt_d   = bcnt_q;
    tcnt_d   = tcnt_q;
    ovr_d    = ovr_q;

    case (state_q)
      ST_IDLE: begin
        if (byte_ok) begin
          cmd_d  = rx_data;
          dat_d  = '0;
          bcnt_d = '0;
          tcnt_d = '0;
          state_d = rx_data[CMD_WE_BIT] ? ST_DATA : ST_BUS;
        end
      end
      ST_DATA: begin
        // Chip-select rising mid-payload abandons the frame without touching the bus.
        if (rx_idle) begin
          state_d = ST_IDLE;
        end else if (rx_stb) begin
          dat_d  = DATA_W'({dat_q, rx_data});
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == LAST_BYTE) begin
            tcnt_d  = '0;
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (wb_err_i) begin
          status_d = STAT_ERR;
          rdata_d  = '0;
          state_d  = ST_RESP;
        end else if (wb_ack_i) begin
          status_d = STAT_OK;
          rdata_d  = cmd_q[CMD_WE_BIT] ? '0 : wb_dat_i;
          state_d  = ST_RESP;
        end else if (TIMEOUT != 0 && tcnt_q == TO_LAST) begin
          status_d = STAT_TIMEOUT;
          rdata_d  = '0;
          state_d  = ST_RESP;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rx_idle) begin
      ovr_d = 1'b0;
    end else if (rx_stb && (state_q == ST_BUS || state_q == ST_RESP)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      status_q <= STAT_OK;
      cmd_q    <= '0;
      dat_q    <= '0;
      rdata_q  <= '0;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
      ovr_q    <= 1'b0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cmd_q    <= cmd_d;
      dat_q    <= dat_d;
      rdata_q  <= rdata_d;
      bcnt_q   <= bcnt_d;
      tcnt_q   <= tcnt_d;
      ovr_q    <= ovr_d;
      sel_q    <= '1;
    end
  end

  // Bus strobes come straight from the state register so reset drops them without a clock.
  assign wb_cyc_o  = (state_q == ST_BUS);
  assign wb_stb_o  = (state_q == ST_BUS);
  assign wb_we_o   = cmd_q[CMD_WE_BIT];
  assign wb_adr_o  = ADDR_W'(cmd_q[CMD_ADDR_MSB:0]) << AL;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign tx_stb    = (state_q == ST_RESP);
  assign tx_data   = rdata_q;
  assign tx_status = status_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_spi_wb_cmd_decoder.sv
// tb/tb_spi_wb_cmd_decoder.sv - self-checking bench: directed vectors, corner sequences, random frames
module tb_spi_wb_cmd_decoder;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_stb = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_idle = 1'b0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [15:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        tx_stb;
  logic [31:0] tx_data;
  logic [1:0]  tx_status;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  spi_wb_cmd_decoder #(.DATA_W(32), .ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_stb(rx_stb), .rx_data(rx_data), .rx_idle(rx_idle),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .tx_stb(tx_stb), .tx_data(tx_data), .tx_status(tx_status),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        started;
    logic [15:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        stable;
    int          cyc;
    logic        tx;
    logic [1:0]  status;
    logic [31:0] data;
    logic        tx_after;
  } res_t;

  // mode: 0 = ack, 1 = err only, 2 = ack and err together
  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] wdata;
    int          delay;
    int          mode;
    logic [31:0] rdata;
    logic [15:0] exp_adr;
    logic        exp_we;
    logic [1:0]  exp_status;
    logic [31:0] exp_data;
    int          exp_cyc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_stb  = 1'b1;
    step();
    rx_stb  = 1'b0;
  endtask

  task automatic pulse_idle();
    rx_idle = 1'b1;
    step();
    rx_idle = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] wdata, input int delay,
                           input int mode, input logic [31:0] rdata, input bit inject,
                           input int gap, output res_t r);
    int n;
    send_byte(cmd);
    if (cmd[7]) begin
      for (int i = 3; i >= 0; i--) begin
        repeat (gap) step();
        send_byte(wdata[i*8 +: 8]);
      end
    end
    n = 0;
    while (wb_cyc_o !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    r.started = wb_cyc_o;
    r.adr     = wb_adr_o;
    r.we      = wb_we_o;
    r.dat     = wb_dat_o;
    r.sel     = wb_sel_o;
    r.stable  = 1'b1;
    r.cyc     = 0;
    if (r.started) begin
      for (int k = 0; k < 20; k++) begin
        wb_dat_i = $urandom;
        if (k == delay) begin
          wb_ack_i = (mode != 1);
          wb_err_i = (mode != 0);
          wb_dat_i = rdata;
        end
        if (inject && k == 0) begin
          rx_stb  = 1'b1;
          rx_data = 8'($urandom);
        end
        if (wb_adr_o !== r.adr || wb_dat_o !== r.dat || wb_we_o !== r.we || wb_stb_o !== 1'b1)
          r.stable = 1'b0;
        step();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        rx_stb   = 1'b0;
        r.cyc++;
        if (wb_cyc_o !== 1'b1) break;
      end
    end
    r.tx     = tx_stb;
    r.status = tx_status;
    r.data   = tx_data;
    step();
    r.tx_after = tx_stb;
  endtask

  task automatic check_frame(input string tag, input res_t r, input logic [15:0] e_adr,
                             input logic e_we, input logic [31:0] e_dat, input logic [1:0] e_st,
                             input logic [31:0] e_data, input int e_cyc);
    chk({tag, " cyc_started"}, 64'(r.started), 64'(1));
    chk({tag, " adr"}, 64'(r.adr), 64'(e_adr));
    chk({tag, " we"}, 64'(r.we), 64'(e_we));
    if (e_we) chk({tag, " dat_o"}, 64'(r.dat), 64'(e_dat));
    chk({tag, " sel"}, 64'(r.sel), 64'hF);
    chk({tag, " bus_stable"}, 64'(r.stable), 64'(1));
    chk({tag, " cyc_cycles"}, 64'(r.cyc), 64'(e_cyc));
    chk({tag, " tx_stb"}, 64'(r.tx), 64'(1));
    chk({tag, " tx_status"}, 64'(r.status), 64'(e_st));
    chk({tag, " tx_data"}, 64'(r.data), 64'(e_data));
    chk({tag, " tx_stb_one_cycle"}, 64'(r.tx_after), 64'(0));
  endtask

  initial begin
    vec_t        vecs[6];
    res_t        r;
    logic        seen;
    logic        ovr_m;
    logic [7:0]  cmd;
    logic [31:0] wd, rd;
    int          dly, md;
    bit          inj;
    logic [1:0]  e_st;

    vecs[0] = '{8'h85, 32'hDEADBEEF, 2, 0, 32'hCAFEF00D, 16'h0014, 1'b1, 2'd0, 32'h0, 3};
    vecs[1] = '{8'h03, 32'h0, 0, 0, 32'h12345678, 16'h000C, 1'b0, 2'd0, 32'h12345678, 1};
    vecs[2] = '{8'h01, 32'h0, 0, 2, 32'h55AA55AA, 16'h0004, 1'b0, 2'd1, 32'h0, 1};
    vecs[3] = '{8'h02, 32'h0, 99, 0, 32'h0, 16'h0008, 1'b0, 2'd2, 32'h0, 4};
    vecs[4] = '{8'hFF, 32'h01020304, 3, 0, 32'h77777777, 16'h01FC, 1'b1, 2'd0, 32'h0, 4};
    vecs[5] = '{8'h7F, 32'h0, 3, 1, 32'h99999999, 16'h01FC, 1'b0, 2'd1, 32'h0, 4};

    repeat (3) @(posedge clk);
    #1;
    chk("reset bus_ctl", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, tx_stb, tx_status, overrun}), 64'(0));
    chk("reset adr_dat", 64'({wb_adr_o, wb_dat_o}), 64'(0));
    chk("reset tx_data", 64'(tx_data), 64'(0));
    rst_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].cmd, vecs[i].wdata, vecs[i].delay, vecs[i].mode, vecs[i].rdata, 1'b0,
                i % 2, r);
      check_frame($sformatf("vec%0d", i), r, vecs[i].exp_adr, vecs[i].exp_we, vecs[i].wdata,
                  vecs[i].exp_status, vecs[i].exp_data, vecs[i].exp_cyc);
    end
    chk("no_overrun_after_vectors", 64'(overrun), 64'(0));

    // Write aborted by chip-select, then a byte that arrives while chip-select is high.
    send_byte(8'h80);
    send_byte(8'h11);
    pulse_idle();
    rx_idle = 1'b1;
    rx_stb  = 1'b1;
    rx_data = 8'h00;
    step();
    rx_idle = 1'b0;
    rx_stb  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (wb_cyc_o !== 1'b0 || tx_stb !== 1'b0) seen = 1'b1;
      step();
    end
    chk("abort no_cyc_no_resp", 64'(seen), 64'(0));
    chk("abort no_overrun", 64'(overrun), 64'(0));
    run_frame(8'h00, 32'h0, 1, 0, 32'hA5A50001, 1'b0, 0, r);
    check_frame("after_abort", r, 16'h0000, 1'b0, 32'h0, 2'd0, 32'hA5A50001, 2);

    run_frame(8'h10, 32'h0, 2, 0, 32'h0BADCAFE, 1'b1, 0, r);
    check_frame("overrun_frame", r, 16'h0040, 1'b0, 32'h0, 2'd0, 32'h0BADCAFE, 3);
    chk("overrun set", 64'(overrun), 64'(1));
    pulse_idle();
    chk("overrun cleared", 64'(overrun), 64'(0));

    ovr_m = 1'b0;
    for (int n = 0; n < 40; n++) begin
      cmd = 8'($urandom);
      wd  = $urandom;
      rd  = $urandom;
      dly = $urandom_range(0, 5);
      md  = $urandom_range(0, 3);
      md  = (md == 3) ? 2 : ((md == 2) ? 1 : 0);
      inj = ($urandom_range(0, 3) == 0);
      run_frame(cmd, wd, dly, md, rd, inj, $urandom_range(0, 2), r);
      e_st = (dly >= TO) ? 2'd2 : ((md != 0) ? 2'd1 : 2'd0);
      check_frame($sformatf("rand%0d", n), r, 16'((cmd % 128) * 4), cmd[7], wd, e_st,
                  (e_st == 2'd0 && !cmd[7]) ? rd : 32'h0, (dly >= TO) ? TO : dly + 1);
      if (inj) ovr_m = 1'b1;
      chk($sformatf("rand%0d overrun", n), 64'(overrun), 64'(ovr_m));
      if ($urandom_range(0, 3) == 0) begin
        pulse_idle();
        ovr_m = 1'b0;
      end
      repeat ($urandom_range(0, 2)) step();
    end

    // Asynchronous reset in the middle of a bus cycle.
    send_byte(8'h03);
    chk("pre_reset cyc", 64'(wb_cyc_o), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (tx_stb !== 1'b0 || wb_cyc_o !== 1'b0) seen = 1'b1;
      step();
    end
    chk("async_reset no_resp", 64'(seen), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
